// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation window loader.
//   - State encoding of the loader FSM
//   - Memory geometry: reference block 16x16, search window 32x32
//   - Pixel width
package me_pkg;

  localparam int REF_WORDS  = 256;
  localparam int SRCH_WORDS = 1024;
  localparam int REF_AW     = 8;
  localparam int SRCH_AW    = 10;
  localparam int PIX_W      = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_REF  = 3'd1,
    LOAD_SRCH = 3'd2,
    START     = 3'd3,
    WAIT_ME   = 3'd4
  } meState_t;

endpackage

// File: rtl/me_wait_timer.sv
// Loadable down-counter that times the motion estimator run.
//   clock, reset_n : clock, asynchronous active-low reset
//   load           : load loadValue into the counter this edge
//   loadValue      : cycle count to load
//   done           : counter has reached its last cycle (count <= 1)
// After a load of N the counter holds N, N-1, ... 1 on successive cycles,
// so done rises N-1 cycles after the cycle the load value first appears.
// The counter parks at zero; with no load pending done simply stays high.
module me_wait_timer #(
  parameter int W = 17
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] loadValue,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count <= W'(1));

endmodule

// File: rtl/me_window_loader.sv
// Loads one 16x16 reference block and one 32x32 search window from a
// pixel stream into the estimator memories, starts the motion estimator
// and waits a fixed number of cycles for its result.
//
// Ports
//   clock, reset_n      : clock, asynchronous active-low reset
//   load_req            : start one load/estimate cycle (honoured in IDLE only)
//   pix_valid/pix_data  : upstream pixel stream, 256 ref then 1024 search pixels
//   pix_ready           : loader accepts a pixel this cycle
//   ref_we/waddr/wdata  : reference memory write port (registered)
//   srch_we/waddr/wdata : search memory write port (registered)
//   me_start            : one-cycle estimator start pulse
//   busy                : high whenever not IDLE
//   result_valid        : one-cycle pulse, estimator outputs are final
//   block_count         : completed cycles, wraps at 16 bits
//   dbg_state           : current FSM state
//
// Handshake: a pixel moves on every rising edge where pix_valid and
// pix_ready are both 1; pix_ready depends only on state, never on pix_valid,
// and the upstream may hold pix_valid low for any number of cycles.
//
// Timing: me_start is high in START, the same cycle as the final search
// write. The wait timer is loaded on entry to START, so result_valid (and
// busy falling) arrive exactly ME_CYCLES cycles after me_start.
// ME_CYCLES must be at least 2.
module me_window_loader
  import me_pkg::*;
#(
  parameter int unsigned ME_CYCLES = 65536
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load_req,
  input  logic                 pix_valid,
  input  logic [PIX_W-1:0]     pix_data,
  output logic                 pix_ready,
  output logic                 ref_we,
  output logic [REF_AW-1:0]    ref_waddr,
  output logic [PIX_W-1:0]     ref_wdata,
  output logic                 srch_we,
  output logic [SRCH_AW-1:0]   srch_waddr,
  output logic [PIX_W-1:0]     srch_wdata,
  output logic                 me_start,
  output logic                 busy,
  output logic                 result_valid,
  output logic [15:0]          block_count,
  output logic [2:0]           dbg_state
);

  localparam int WAIT_W = $clog2(ME_CYCLES + 1);

  meState_t state, stateNext;

  logic [REF_AW-1:0]  refCnt;
  logic [SRCH_AW-1:0] srchCnt;
  logic               xfer;
  logic               refXfer;
  logic               srchXfer;
  logic               refLast;
  logic               srchLast;
  logic               timerLoad;
  logic               timerDone;
  logic               finishing;

  assign pix_ready = (state == LOAD_REF) || (state == LOAD_SRCH);
  assign xfer      = pix_valid & pix_ready;
  assign refXfer   = xfer && (state == LOAD_REF);
  assign srchXfer  = xfer && (state == LOAD_SRCH);
  assign refLast   = refXfer && (refCnt == REF_AW'(REF_WORDS - 1));
  assign srchLast  = srchXfer && (srchCnt == SRCH_AW'(SRCH_WORDS - 1));

  assign me_start  = (state == START);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next state
  always_comb begin
    stateNext = state;
    timerLoad = 1'b0;
    finishing = 1'b0;
    case (state)
      IDLE: begin
        if (load_req) stateNext = LOAD_REF;
      end
      LOAD_REF: begin
        if (refLast) stateNext = LOAD_SRCH;
      end
      LOAD_SRCH: begin
        if (srchLast) begin
          stateNext = START;
          timerLoad = 1'b1;
        end
      end
      START: begin
        stateNext = WAIT_ME;
      end
      WAIT_ME: begin
        if (timerDone) begin
          stateNext = IDLE;
          finishing = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Write ports are registered one cycle behind the transfer; address and
  // data only update on a transfer so they hold while the strobe is low.
  // Counters wrap naturally to zero after their final word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      refCnt       <= '0;
      srchCnt      <= '0;
      ref_we       <= 1'b0;
      ref_waddr    <= '0;
      ref_wdata    <= '0;
      srch_we      <= 1'b0;
      srch_waddr   <= '0;
      srch_wdata   <= '0;
      result_valid <= 1'b0;
      block_count  <= '0;
    end else begin
      ref_we       <= refXfer;
      srch_we      <= srchXfer;
      result_valid <= finishing;
      if (refXfer) begin
        ref_waddr <= refCnt;
        ref_wdata <= pix_data;
        refCnt    <= refCnt + REF_AW'(1);
      end
      if (srchXfer) begin
        srch_waddr <= srchCnt;
        srch_wdata <= pix_data;
        srchCnt    <= srchCnt + SRCH_AW'(1);
      end
      if (finishing) begin
        block_count <= block_count + 16'd1;
      end
    end
  end

  me_wait_timer #(
    .W(WAIT_W)
  ) u_wait_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (timerLoad),
    .loadValue (WAIT_W'(ME_CYCLES)),
    .done      (timerDone)
  );

endmodule

// File: doc/me_window_loader.md
ME_WINDOW_LOADER -- requirements
Module: me_window_loader

Interface
REQ-001 Parameter ME_CYCLES, default 65536, cycles the loader waits after issuing start before the motion estimator result is treated as final.
REQ-002 clock  input  1  single clock for all state; rising-edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 load_req  input  1  request to load one reference block plus search window; sampled only in IDLE.
REQ-005 pix_valid  input  1  upstream pixel valid.
REQ-006 pix_data  input  8  upstream pixel; 256 reference pixels raster-order, then 1024 search pixels raster-order.
REQ-007 pix_ready  output  1  loader accepts pixel this cycle.
REQ-008 ref_we  output  1  reference memory write strobe.
REQ-009 ref_waddr  output  8  reference memory write address (row*16+col).
REQ-010 ref_wdata  output  8  reference memory write data.
REQ-011 srch_we  output  1  search memory write strobe.
REQ-012 srch_waddr  output  10  search memory write address (row*32+col).
REQ-013 srch_wdata  output  8  search memory write data.
REQ-014 me_start  output  1  one-cycle start pulse to motion_estimator.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 result_valid  output  1  one-cycle pulse: estimator outputs (bestDist, motionX, motionY) are final.
REQ-017 block_count  output  16  number of completed load/estimate cycles, wraps at 65535->0.

Function
REQ-018 States SHALL be IDLE, LOAD_REF, LOAD_SRCH, START, WAIT_ME; encoding in package.
REQ-019 IDLE -> LOAD_REF on load_req=1; load_req in any other state SHALL be ignored (no queuing).
REQ-020 pix_ready SHALL be 1 exactly in LOAD_REF and LOAD_SRCH; transfer = pix_valid & pix_ready.
REQ-021 Each transfer in LOAD_REF SHALL produce, next cycle, ref_we=1, ref_waddr=ref counter, ref_wdata=pixel; counter 8 bits from 0.
REQ-022 Each transfer in LOAD_SRCH SHALL produce, next cycle, srch_we=1, srch_waddr=search counter, srch_wdata=pixel; counter 10 bits from 0.
REQ-023 Write strobes SHALL be 0 on any cycle without a preceding transfer; ref_we and srch_we never both 1.
REQ-024 Transfer with ref counter=255 SHALL move LOAD_REF -> LOAD_SRCH; counter wraps to 0.
REQ-025 Transfer with search counter=1023 SHALL move LOAD_SRCH -> START; counter wraps to 0.
REQ-026 START SHALL last one cycle, drive me_start=1 (coincident with final srch_we), go to WAIT_ME.
REQ-027 WAIT_ME SHALL count ME_CYCLES cycles, then pulse result_valid for one cycle, increment block_count, return to IDLE.
REQ-028 pix_valid deasserted mid-load SHALL stall counters and writes without error; no timeout.
REQ-029 Address/data outputs SHALL hold last value when strobes are 0.

Reset
REQ-030 reset_n=0 SHALL asynchronously force IDLE, all counters 0, block_count 0, and all outputs 0.
REQ-031 Reset mid-load or mid-wait SHALL abandon the block; no me_start or result_valid issued for it.
REQ-032 First load_req SHALL be honoured on the first rising edge after reset_n deasserts.

Structure
REQ-033 Package me_pkg SHALL hold: state enum, REF_WORDS=256, SRCH_WORDS=1024, REF_AW=8, SRCH_AW=10, PIX_W=8.
REQ-034 One sub-module me_wait_timer (loadable down-counter, done flag) SHALL implement the WAIT_ME delay; all else flat.
REQ-035 Wait counter width SHALL be ceil(log2(ME_CYCLES+1)) bits.

Verification
REQ-036 Reset, load_req=1, 1280 continuous pixels value=addr mod 256 -> ref writes 0..255, srch writes 0..1023, me_start exactly once at cycle after last transfer.
REQ-037 ME_CYCLES=16: after me_start, result_valid pulse 16 cycles later; block_count 0->1; busy falls same cycle.
REQ-038 pix_valid toggling 1,0,0,1 throughout -> identical write sequence to REQ-036, no skipped/duplicated addresses.
REQ-039 load_req pulsed during LOAD_SRCH and WAIT_ME -> ignored; exactly one result_valid; block_count=1.
REQ-040 reset_n=0 after 300 transfers -> all outputs 0 asynchronously; new load restarts at ref_waddr=0, srch_waddr=0.
REQ-041 With refmem/searchmem models and motion_estimator attached, full load -> srch_waddr reaches 1023, result_valid fires, estimator bestDist/motionX/motionY match golden.
